// File: rtl/bk_frame_accumulator.sv
// Streaming frame accumulator around an external 12-bit Brent-Kung adder:
// sums LEN samples per frame and hands out the total with a sticky carry flag.
module bk_frame_accumulator #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_data,
  output logic [23:0] add_inputs,
  input  logic [12:0] add_outs,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_sum,
  output logic        out_ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [11:0]      acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_acc_reg;
  logic             out_valid_reg;
  logic [11:0]      out_sum_reg;
  logic             out_ovf_reg;

  logic        cnt_zero;
  logic        cnt_last;
  logic [11:0] opa;
  logic [11:0] sum;
  logic        cy;
  logic        ovf_next;
  logic        acc_fire;
  logic        frame_end;

  assign cnt_zero = (cnt_reg == '0);
  assign cnt_last = (cnt_reg == LAST_CNT);

  // First sample of a frame adds to zero, so a stale acc never leaks in.
  assign opa = cnt_zero ? 12'd0 : acc_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_interleave
      assign add_inputs[2*gi]   = opa[gi];
      assign add_inputs[2*gi+1] = in_data[gi];
    end
  endgenerate

  assign sum      = add_outs[11:0];
  assign cy       = add_outs[12];
  assign ovf_next = (~cnt_zero & ovf_acc_reg) | cy;

  // Only a completing frame needs the output slot, so stall just that case.
  assign in_ready  = ~(cnt_last & out_valid_reg & ~out_ready);
  assign acc_fire  = in_valid & in_ready;
  assign frame_end = acc_fire & cnt_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_acc_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      if (acc_fire) begin
        if (cnt_last) begin
          out_sum_reg <= sum;
          out_ovf_reg <= ovf_next;
          cnt_reg     <= '0;
          acc_reg     <= '0;
          ovf_acc_reg <= 1'b0;
        end else begin
          acc_reg     <= sum;
          ovf_acc_reg <= ovf_next;
          cnt_reg     <= cnt_reg + CNT_ONE;
        end
      end
      // A new frame result takes priority over the consumer draining the old one.
      if (frame_end) begin
        out_valid_reg <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_bk_frame_accumulator.sv
// Directed bench for bk_frame_accumulator with LEN=4, LEN=2 and LEN=1 instances,
// each wired to a behavioural model of the external 12-bit adder.
module tb_bk_frame_accumulator;

  logic clk;
  logic rst;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_ovf4;
  logic [11:0] in_data4, out_sum4;
  logic [23:0] add_inputs4;
  logic [12:0] add_outs4;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_ovf2;
  logic [11:0] in_data2, out_sum2;
  logic [23:0] add_inputs2;
  logic [12:0] add_outs2;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_ovf1;
  logic [11:0] in_data1, out_sum1;
  logic [23:0] add_inputs1;
  logic [12:0] add_outs1;

  int checks;
  int errors;

  logic [11:0] bb_smp [8] = '{12'h100, 12'h200, 12'h300, 12'h400,
                              12'hFFF, 12'h002, 12'h800, 12'h800};
  logic [11:0] bb_sum [4] = '{12'h300, 12'h700, 12'h001, 12'h000};
  logic        bb_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  // External adder: de-interleave operands and add with carry-out.
  function automatic logic [12:0] adder_model(input logic [23:0] x);
    logic [11:0] a;
    logic [11:0] b;
    for (int i = 0; i < 12; i++) begin
      a[i] = x[2*i];
      b[i] = x[2*i+1];
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign add_outs4 = adder_model(add_inputs4);
  assign add_outs2 = adder_model(add_inputs2);
  assign add_outs1 = adder_model(add_inputs1);

  bk_frame_accumulator #(.LEN(4), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .add_inputs(add_inputs4), .add_outs(add_outs4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_sum(out_sum4), .out_ovf(out_ovf4)
  );

  bk_frame_accumulator #(.LEN(2), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .add_inputs(add_inputs2), .add_outs(add_outs2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_sum(out_sum2), .out_ovf(out_ovf2)
  );

  bk_frame_accumulator #(.LEN(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .add_inputs(add_inputs1), .add_outs(add_outs1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_sum(out_sum1), .out_ovf(out_ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && in_valid4 && in_ready4) $display("len4 accept data=%h", in_data4);
    if (!rst && in_valid2 && in_ready2) $display("len2 accept data=%h", in_data2);
    if (!rst && in_valid1 && in_ready1) $display("len1 accept data=%h", in_data1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed4(input logic [11:0] d);
    in_valid4 = 1'b1;
    in_data4  = d;
    tick();
  endtask

  task automatic feed2(input logic [11:0] d);
    in_valid2 = 1'b1;
    in_data2  = d;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid4 = 1'b0; in_data4 = 12'h000; out_ready4 = 1'b0;
    in_valid2 = 1'b0; in_data2 = 12'h000; out_ready2 = 1'b0;
    in_valid1 = 1'b0; in_data1 = 12'h000; out_ready1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid4 got %b exp 0", out_valid4); end
    checks++; if (out_sum4 !== 12'h000) begin errors++; $display("FAIL reset_sum4 got %h exp 000", out_sum4); end
    checks++; if (out_ovf4 !== 1'b0) begin errors++; $display("FAIL reset_ovf4 got %b exp 0", out_ovf4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready4 got %b exp 1", in_ready4); end
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid2 got %b exp 0", out_valid2); end
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b exp 0", out_valid1); end
    in_data4 = 12'hFFF;
    #1;
    checks++; if (add_inputs4 !== 24'hAAAAAA) begin errors++; $display("FAIL reset_operands got %h exp AAAAAA", add_inputs4); end
  endtask

  task automatic test_basic();
    out_ready4 = 1'b1;
    feed4(12'd1);
    feed4(12'd2);
    in_valid4 = 1'b1;
    in_data4  = 12'd3;
    #1;
    checks++; if (add_inputs4 !== 24'h00000F) begin errors++; $display("FAIL basic_operands got %h exp 00000F", add_inputs4); end
    tick();
    feed4(12'd4);
    in_valid4 = 1'b0;
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid4); end
    checks++; if (out_sum4 !== 12'd10) begin errors++; $display("FAIL basic_sum got %h exp %h", out_sum4, 12'd10); end
    checks++; if (out_ovf4 !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", out_ovf4); end
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", out_valid4); end
  endtask

  task automatic test_overflow();
    out_ready4 = 1'b1;
    feed4(12'hFFF);
    feed4(12'h001);
    feed4(12'h000);
    feed4(12'h000);
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b exp 1", out_valid4); end
    checks++; if (out_sum4 !== 12'h000) begin errors++; $display("FAIL ovf_sum got %h exp 000", out_sum4); end
    checks++; if (out_ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", out_ovf4); end
    feed4(12'h001);
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL ovf_mid_valid got %b exp 0", out_valid4); end
    feed4(12'h001);
    feed4(12'h001);
    feed4(12'h001);
    in_valid4 = 1'b0;
    checks++; if (out_sum4 !== 12'h004) begin errors++; $display("FAIL ovf_next_sum got %h exp 004", out_sum4); end
    checks++; if (out_ovf4 !== 1'b0) begin errors++; $display("FAIL ovf_next_flag got %b exp 0", out_ovf4); end
    tick();
  endtask

  task automatic test_stall();
    out_ready2 = 1'b0;
    feed2(12'd5);
    feed2(12'd6);
    checks++; if (out_valid2 !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", out_valid2); end
    checks++; if (out_sum2 !== 12'd11) begin errors++; $display("FAIL stall_sum got %h exp %h", out_sum2, 12'd11); end
    in_valid2 = 1'b1;
    in_data2  = 12'd7;
    #1;
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL stall_ready7 got %b exp 1", in_ready2); end
    tick();
    in_data2 = 12'd8;
    #1;
    checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL stall_ready8 got %b exp 0", in_ready2); end
    tick();
    tick();
    checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL stall_hold_ready got %b exp 0", in_ready2); end
    checks++; if (out_sum2 !== 12'd11) begin errors++; $display("FAIL stall_hold_sum got %h exp %h", out_sum2, 12'd11); end
    out_ready2 = 1'b1;
    #1;
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", in_ready2); end
    tick();
    in_valid2 = 1'b0;
    checks++; if (out_valid2 !== 1'b1) begin errors++; $display("FAIL stall_new_valid got %b exp 1", out_valid2); end
    checks++; if (out_sum2 !== 12'd15) begin errors++; $display("FAIL stall_new_sum got %h exp %h", out_sum2, 12'd15); end
    tick();
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", out_valid2); end
  endtask

  task automatic test_back_to_back();
    out_ready2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid2 = 1'b1;
      in_data2  = bb_smp[i];
      #1;
      checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready2); end
      tick();
      if (i % 2 == 1) begin
        checks++; if (out_valid2 !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, out_valid2); end
        checks++; if (out_sum2 !== bb_sum[i/2]) begin errors++; $display("FAIL b2b_sum[%0d] got %h exp %h", i, out_sum2, bb_sum[i/2]); end
        checks++; if (out_ovf2 !== bb_ovf[i/2]) begin errors++; $display("FAIL b2b_ovf[%0d] got %b exp %b", i, out_ovf2, bb_ovf[i/2]); end
      end else begin
        checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL b2b_gap[%0d] got %b exp 0", i, out_valid2); end
      end
    end
    in_valid2 = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    out_ready4 = 1'b0;
    feed4(12'd1);
    feed4(12'd2);
    feed4(12'd3);
    feed4(12'd4);
    checks++; if (out_sum4 !== 12'd10) begin errors++; $display("FAIL rstmid_held got %h exp %h", out_sum4, 12'd10); end
    feed4(12'd5);
    feed4(12'd6);
    in_valid4 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", out_valid4); end
    checks++; if (out_sum4 !== 12'h000) begin errors++; $display("FAIL rstmid_sum got %h exp 000", out_sum4); end
    out_ready4 = 1'b1;
    feed4(12'd1);
    feed4(12'd1);
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL rstmid_early got %b exp 0", out_valid4); end
    feed4(12'd1);
    feed4(12'd1);
    in_valid4 = 1'b0;
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL rstmid_fresh_valid got %b exp 1", out_valid4); end
    checks++; if (out_sum4 !== 12'd4) begin errors++; $display("FAIL rstmid_fresh_sum got %h exp 004", out_sum4); end
    tick();
  endtask

  task automatic test_len1();
    logic [11:0] smp [2];
    logic [23:0] exp_ops;
    smp[0] = 12'hABC;
    smp[1] = 12'h123;
    out_ready1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid1 = 1'b1;
      in_data1  = smp[k];
      exp_ops   = '0;
      for (int i = 0; i < 12; i++) exp_ops[2*i+1] = smp[k][i];
      #1;
      checks++; if (add_inputs1 !== exp_ops) begin errors++; $display("FAIL len1_ops[%0d] got %h exp %h", k, add_inputs1, exp_ops); end
      tick();
      checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL len1_valid[%0d] got %b exp 1", k, out_valid1); end
      checks++; if (out_sum1 !== smp[k]) begin errors++; $display("FAIL len1_sum[%0d] got %h exp %h", k, out_sum1, smp[k]); end
      checks++; if (out_ovf1 !== 1'b0) begin errors++; $display("FAIL len1_ovf[%0d] got %b exp 0", k, out_ovf1); end
    end
    in_valid1 = 1'b0;
    tick();
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL len1_drain got %b exp 0", out_valid1); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_reset_midframe();
    test_len1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
